mem_arbiter_rr: RTL and testbench
=================================

# mem_arbiter_rr

Round-robin arbiter that shares the single-port shared memory between up to `NUM_REQ` client modules (incrementers, readers, display fetchers). Each client raises a request, waits for its one-hot grant, and holds the grant for as many cycles as it needs. This gives each client atomic read-modify-write semantics. The arbiter multiplexes the owning client's address, read/write flag and write data onto the memory port and broadcasts read data back. A hold-time watchdog revokes a grant that a misbehaving client never releases.

## Interface
Parameters:
- `NUM_REQ`, 4: number of clients, 2..8.
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 32: memory data width.
- `MAX_HOLD`, 1024: maximum cycles a grant may be held before revocation, ≥ 4.

Ports:
- `clk`  in  1  the only clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-client request level; held high for the whole access.
- `req_addr`  in  NUM_REQ*ADDR_W  client addresses, client i at bits [i*ADDR_W +: ADDR_W].
- `req_rw`  in  NUM_REQ  per-client flag; 1 = read, 0 = write.
- `req_wdata`  in  NUM_REQ*DATA_W  client write data, packed like `req_addr`.
- `grant`  out  NUM_REQ  registered, one-hot or zero.
- `rdata`  out  DATA_W  combinational copy of `mem_rdata`, shared by all clients.
- `mem_addr`  out  ADDR_W  address to memory.
- `mem_rw`  out  1  read/write flag to memory.
- `mem_wdata`  out  DATA_W  write data to memory.
- `mem_rdata`  in  DATA_W  read data from memory.
- `owner_id`  out  $clog2(NUM_REQ)  index of the current or last owner.
- `busy`  out  1  high while any grant is active.
- `timeout_err`  out  1  sticky; set on revocation.
- `timeout_id`  out  $clog2(NUM_REQ)  client that was revoked.
- `err_clr`  in  1  single-cycle pulse; clears `timeout_err`.

## Operation
- States are `IDLE` and `GRANTED`.
- `IDLE`:
  - Each edge, compute eligible requests: `req & ~blocked`.
  - If any eligible request exists, pick the first one searching circularly from `(owner_id+1) mod NUM_REQ`.
  - Register `grant[pick]`, `owner_id`, `busy`=1, clear the hold counter, go to `GRANTED`.
- `GRANTED`:
  - If `req[owner_id]`=0, clear `grant` and `busy` and go to `IDLE`.
  - Otherwise, if the hold counter equals `MAX_HOLD-1`:
    - Revoke: clear `grant` and `busy`, go to `IDLE`.
    - Set `blocked[owner_id]`, set `timeout_err`, set `timeout_id` = `owner_id`.
  - Otherwise increment the hold counter.
- `blocked[i]` clears on any edge where `req[i]`=0. A revoked client must drop its request before it can be granted again.
- Requests from non-owners are ignored while in `GRANTED`; there is no preemption.
- Memory mux:
  - While `busy`=1, `mem_addr`, `mem_rw` and `mem_wdata` are combinational selects of the `owner_id` lanes.
  - While `busy`=0, they are forced to 0, 1 and 0. No write can occur without an owner.
- If `err_clr` and a new revocation occur in the same cycle, the revocation wins and `timeout_err` stays 1.
- Reset values: `grant`=0, `busy`=0, `owner_id`=NUM_REQ-1 (so client 0 has first priority), `blocked`=0, hold counter=0, `timeout_err`=0, `timeout_id`=0, state `IDLE`.
- Reset mid-access drops the grant immediately, asynchronously. The memory mux falls to the idle values in the same instant.

## Timing
- Grant latency: request sampled high at edge E in `IDLE` gives `grant` high after E.
- The client sees `grant` one cycle after raising its request, provided the arbiter is idle and the client has priority.
- Release: `req` sampled low at edge E gives `grant` low after E. The earliest next grant is after E+1, so there is at least one no-owner cycle between owners.
- Maximum hold: `MAX_HOLD` cycles with `grant` high, counted from the first cycle `grant` is high.
- The memory port follows `owner_id` combinationally. Client lane changes appear on `mem_*` in the same cycle.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum `arb_state_t` {`IDLE`, `GRANTED`};
  - default width constants `MEM_ADDR_W`=8 and `MEM_DATA_W`=32;
  - the idle-bus constant `MEM_RW_READ`=1'b1.
- One sub-module, `mem_arb_rr_pick`: combinational circular priority picker.
  - Inputs: eligible mask, start index.
  - Outputs: `valid`, index.
- The top level holds the FSM, hold counter, `blocked` mask, error registers and data mux.

## Test plan
- Single client: `req`=4'b0001 at cycle 5 gives `grant`=0001 at cycle 6. Client writes 0x2A to address 0x18 with `mem_rw`=0, then drops `req`. `grant`=0 next cycle; the bus returns to address 0, `mem_rw`=1.
- Fairness: `req`=4'b1111 held continuously, each client holding for 3 cycles then re-requesting. Grant order is 0,1,2,3,0. No client is granted twice before all others are served.
- Atomic increment: two incrementer models both read-modify-write address 0x18, 100 times each. The final memory value is 200 and `grant` is never multi-hot.
- Watchdog with `MAX_HOLD`=16: client 2 holds `req` indefinitely.
  - Grant is revoked after 16 granted cycles; `timeout_err`=1, `timeout_id`=2.
  - Client 2 is not re-granted until its `req` drops.
  - Client 1 is granted next.
- Error clear: `err_clr` pulse clears `timeout_err`. An `err_clr` pulse coincident with a new revocation leaves `timeout_err`=1.
- Reset mid-access: assert `rst_n`=0 while client 1 is writing. `grant`=0, `mem_rw`=1 and `mem_addr`=0 immediately. After release, client 0 wins a simultaneous `req`=4'b0011.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

    localparam int   MEM_ADDR_W  = 8;
    localparam int   MEM_DATA_W  = 32;
    localparam logic MEM_RW_READ = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Client request lanes plus the single shared memory port.
interface mem_arbiter_rr_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_rw;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        grant;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_rw;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic [ID_W-1:0]           owner_id;
    logic                      busy;
    logic                      timeout_err;
    logic [ID_W-1:0]           timeout_id;
    logic                      err_clr;

    modport slave (
        input  req, req_addr, req_rw, req_wdata, mem_rdata, err_clr,
        output grant, rdata, mem_addr, mem_rw, mem_wdata, owner_id, busy,
               timeout_err, timeout_id
    );

    modport master (
        output req, req_addr, req_rw, req_wdata, mem_rdata, err_clr,
        input  grant, rdata, mem_addr, mem_rw, mem_wdata, owner_id, busy,
               timeout_err, timeout_id
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Circular priority picker: first set bit of i_mask at or after i_start, wrapping.
module mem_arb_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_mask,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    int               w_pos;
    logic [IDX_W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest eligible client is written last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        w_cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = int'(i_start) + k;
            if (w_pos >= N) w_pos = w_pos - N;
            w_cand = IDX_W'(w_pos);
            if (i_mask[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin owner arbitration for a single-port memory with a hold-time watchdog.
module mem_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int MAX_HOLD = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_rr_if.slave arb_if
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [ID_W-1:0]   LAST_ID    = ID_W'(NUM_REQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    arb_state_t         r_state,   w_state_nxt;
    logic [NUM_REQ-1:0] r_grant,   w_grant_nxt;
    logic [ID_W-1:0]    r_owner,   w_owner_nxt;
    logic               r_busy,    w_busy_nxt;
    logic [HOLD_W-1:0]  r_hold,    w_hold_nxt;
    logic [NUM_REQ-1:0] r_blocked, w_blocked_nxt;
    logic               r_err,     w_err_nxt;
    logic [ID_W-1:0]    r_tid,     w_tid_nxt;

    logic [ID_W-1:0]    w_start;
    logic               w_pick_valid;
    logic [ID_W-1:0]    w_pick_idx;

    assign w_start = (r_owner == LAST_ID) ? '0 : r_owner + 1'b1;

    mem_arb_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .i_mask  (arb_if.req & ~r_blocked),
        .i_start (w_start),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        // NOTE: every next value starts as a hold of its register so no branch can infer a latch.
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_owner_nxt   = r_owner;
        w_busy_nxt    = r_busy;
        w_hold_nxt    = r_hold;
        w_blocked_nxt = r_blocked & arb_if.req;
        w_err_nxt     = r_err & ~arb_if.err_clr;
        w_tid_nxt     = r_tid;

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt = NUM_REQ'(1) << w_pick_idx;
                    w_owner_nxt = w_pick_idx;
                    w_busy_nxt  = 1'b1;
                    w_hold_nxt  = '0;
                    w_state_nxt = GRANTED;
                end
            end
            GRANTED: begin
                if (!arb_if.req[r_owner]) begin
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (r_hold == HOLD_LIMIT) begin
                    // Revocation outranks a simultaneous err_clr.
                    w_grant_nxt            = '0;
                    w_busy_nxt             = 1'b0;
                    w_state_nxt            = IDLE;
                    w_blocked_nxt[r_owner] = 1'b1;
                    w_err_nxt              = 1'b1;
                    w_tid_nxt              = r_owner;
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_owner   <= LAST_ID;
            r_busy    <= 1'b0;
            r_hold    <= '0;
            r_blocked <= '0;
            r_err     <= 1'b0;
            r_tid     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_owner   <= w_owner_nxt;
            r_busy    <= w_busy_nxt;
            r_hold    <= w_hold_nxt;
            r_blocked <= w_blocked_nxt;
            r_err     <= w_err_nxt;
            r_tid     <= w_tid_nxt;
        end
    end

    // Without an owner the port idles as a read of address 0, so no stray write can land.
    always_comb begin
        arb_if.mem_addr  = '0;
        arb_if.mem_rw    = MEM_RW_READ;
        arb_if.mem_wdata = '0;
        if (r_busy) begin
            arb_if.mem_addr  = arb_if.req_addr[r_owner*ADDR_W +: ADDR_W];
            arb_if.mem_rw    = arb_if.req_rw[r_owner];
            arb_if.mem_wdata = arb_if.req_wdata[r_owner*DATA_W +: DATA_W];
        end
    end

    assign arb_if.grant       = r_grant;
    assign arb_if.owner_id    = r_owner;
    assign arb_if.busy        = r_busy;
    assign arb_if.timeout_err = r_err;
    assign arb_if.timeout_id  = r_tid;
    assign arb_if.rdata       = arb_if.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed and randomized checks of mem_arbiter_rr against a cycle-level behavioural model.
module tb_mem_arbiter_rr;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int MH  = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_clear;
    logic [DW-1:0] mem [256];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter_rr_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter_rr #(
        .NUM_REQ  (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_HOLD (MH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (bus)
    );

    // Shared memory behind the arbiter: synchronous write, combinational read.
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (!bus.mem_rw) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] d);
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_rw[i]             = rw;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Behavioural model state: owner (or last owner), granted-cycle count, blocked flags, error.
    int   m_last, m_held, m_tid;
    bit   m_busy, m_err;
    bit   m_blk [N];

    task automatic model_edge(input logic [N-1:0] r_in, input logic e_in);
        bit rev, found;
        int c;
        rev = 0;
        found = 0;
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && r_in[c] && !m_blk[c]) begin
                    found  = 1;
                    m_last = c;
                    m_busy = 1;
                    m_held = 1;
                end
            end
        end else if (!r_in[m_last]) begin
            m_busy = 0;
        end else if (m_held == MH) begin
            m_busy = 0;
            rev    = 1;
        end else begin
            m_held++;
        end
        for (int i = 0; i < N; i++) if (!r_in[i]) m_blk[i] = 0;
        if (rev) begin
            m_blk[m_last] = 1;
            m_err = 1;
            m_tid = m_last;
        end else if (e_in) begin
            m_err = 0;
        end
    endtask

    initial begin
        int cnt, guard, bad, ones;
        logic [N-1:0] g, prev_g, seen;
        int order [$];
        int exp_order [5];
        int held [N];
        int ph [2], done [2];
        logic [DW-1:0] val;
        logic [N-1:0] r_snap;
        logic e_snap;

        bus.req = '0; bus.req_addr = '0; bus.req_rw = '1; bus.req_wdata = '0;
        bus.err_clr = 1'b0;
        mem_clear = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        check("rst_grant", bus.grant, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_owner", bus.owner_id, N - 1);
        check("rst_terr", bus.timeout_err, 0);
        check("rst_tid", bus.timeout_id, 0);
        check("rst_mem_rw", bus.mem_rw, 1);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        mem_clear = 1'b0;
        rst_n = 1'b1;

        // Single client write.
        repeat (3) step();
        set_lane(0, 8'h18, 1'b0, 32'h2A);
        bus.req = 4'b0001;
        step();
        check("single_grant", bus.grant, 4'b0001);
        check("single_busy", bus.busy, 1);
        check("single_owner", bus.owner_id, 0);
        check("single_addr", bus.mem_addr, 8'h18);
        check("single_rw", bus.mem_rw, 0);
        check("single_wdata", bus.mem_wdata, 32'h2A);
        step();
        check("single_hold", bus.grant, 4'b0001);
        bus.req = '0;
        step();
        check("single_release", bus.grant, 0);
        check("single_idle_busy", bus.busy, 0);
        check("single_idle_addr", bus.mem_addr, 0);
        check("single_idle_rw", bus.mem_rw, 1);
        check("single_idle_wdata", bus.mem_wdata, 0);
        check("single_mem", mem[8'h18], 32'h2A);
        check("single_rdata", bus.rdata, mem[0]);

        // Fairness with all clients requesting and re-requesting.
        set_lane(0, 8'h00, 1'b1, '0);
        do_reset();
        exp_order = '{0, 1, 2, 3, 0};
        held = '{default: 0};
        bad = 0;
        prev_g = '0;
        bus.req = 4'b1111;
        for (int cyc = 0; cyc < 80 && order.size() < 5; cyc++) begin
            step();
            g = bus.grant;
            if ($countones(g) > 1) bad++;
            if (g != 0 && prev_g != 0 && g != prev_g) bad++;
            if (g != 0 && g != prev_g) begin
                for (int i = 0; i < N; i++) if (g[i]) order.push_back(i);
            end
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    held[i]++;
                    if (held[i] == 3) begin
                        bus.req[i] = 1'b0;
                        held[i] = 0;
                    end
                end else if (!bus.req[i]) begin
                    bus.req[i] = 1'b1;
                end
            end
            prev_g = g;
        end
        check("fair_count", order.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < order.size()) check($sformatf("fair_order%0d", k), order[k], exp_order[k]);
        end
        check("fair_violations", bad, 0);
        bus.req = '0;
        repeat (2) step();

        // Two incrementers doing read-modify-write on the same address.
        mem_clear = 1'b1;
        step();
        mem_clear = 1'b0;
        set_lane(0, 8'h18, 1'b1, '0);
        set_lane(1, 8'h18, 1'b1, '0);
        ph = '{0, 0};
        done = '{0, 0};
        bad = 0;
        bus.req = 4'b0011;
        for (int cyc = 0; cyc < 4000 && (done[0] < 100 || done[1] < 100); cyc++) begin
            step();
            g = bus.grant;
            if ($countones(g) > 1) bad++;
            for (int c = 0; c < 2; c++) begin
                case (ph[c])
                    0: if (g[c]) begin
                        val = bus.rdata;
                        set_lane(c, 8'h18, 1'b0, val + 1);
                        ph[c] = 1;
                    end
                    1: begin
                        bus.req[c] = 1'b0;
                        set_lane(c, 8'h18, 1'b1, '0);
                        done[c]++;
                        ph[c] = 2;
                    end
                    default: begin
                        if (done[c] < 100) bus.req[c] = 1'b1;
                        ph[c] = 0;
                    end
                endcase
            end
        end
        check("inc_done0", done[0], 100);
        check("inc_done1", done[1], 100);
        check("inc_multihot", bad, 0);
        check("inc_final", mem[8'h18], 200);
        bus.req = '0;
        repeat (2) step();

        // Watchdog: client 2 never releases.
        bus.req = 4'b0100;
        guard = 0;
        do begin
            step();
            guard++;
        end while (!bus.grant[2] && guard < 10);
        check("wd_grant2", bus.grant, 4'b0100);
        cnt = 1;
        bus.req[1] = 1'b1;
        guard = 0;
        while (bus.grant[2] && guard < 40) begin
            step();
            guard++;
            if (bus.grant[2]) cnt++;
        end
        check("wd_hold_cycles", cnt, MH);
        check("wd_revoked", bus.grant, 0);
        check("wd_busy", bus.busy, 0);
        check("wd_terr", bus.timeout_err, 1);
        check("wd_tid", bus.timeout_id, 2);
        step();
        check("wd_next_client1", bus.grant, 4'b0010);
        check("wd_next_owner", bus.owner_id, 1);
        step();
        bus.req[1] = 1'b0;
        step();
        check("wd_client1_release", bus.grant, 0);
        seen = '0;
        repeat (4) begin
            step();
            seen |= bus.grant;
        end
        check("wd_blocked", seen, 0);
        bus.req[2] = 1'b0;
        step();
        bus.req[2] = 1'b1;
        step();
        check("wd_regrant2", bus.grant, 4'b0100);

        // Error clear, then a clear coincident with a fresh revocation.
        cnt = 1;
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        cnt++;
        check("clr_terr", bus.timeout_err, 0);
        while (cnt < MH) begin
            step();
            cnt++;
        end
        check("clr_still_granted", bus.grant, 4'b0100);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("clr_race_revoked", bus.grant, 0);
        check("clr_race_terr", bus.timeout_err, 1);
        check("clr_race_tid", bus.timeout_id, 2);
        bus.req = '0;
        step();

        // Asynchronous reset during a client 1 write.
        set_lane(1, 8'h33, 1'b0, 32'hDEAD_BEEF);
        bus.req = 4'b0010;
        step();
        check("rstmid_grant", bus.grant, 4'b0010);
        check("rstmid_rw", bus.mem_rw, 0);
        check("rstmid_addr", bus.mem_addr, 8'h33);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_grant0", bus.grant, 0);
        check("rstmid_busy0", bus.busy, 0);
        check("rstmid_rw1", bus.mem_rw, 1);
        check("rstmid_addr0", bus.mem_addr, 0);
        check("rstmid_wdata0", bus.mem_wdata, 0);
        check("rstmid_terr0", bus.timeout_err, 0);
        set_lane(0, 8'h00, 1'b1, '0);
        set_lane(1, 8'h00, 1'b1, '0);
        bus.req = 4'b0011;
        rst_n = 1'b1;
        step();
        check("rstmid_after_grant", bus.grant, 4'b0001);
        check("rstmid_after_owner", bus.owner_id, 0);
        bus.req = '0;

        // Randomized traffic against the behavioural model.
        do_reset();
        m_last = N - 1; m_held = 0; m_tid = 0; m_busy = 0; m_err = 0;
        m_blk = '{default: 0};
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) begin
                    if ($urandom_range(11) == 0) bus.req[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    bus.req[i] = 1'b1;
                end
                set_lane(i, AW'($urandom), 1'($urandom), $urandom);
            end
            bus.err_clr = ($urandom_range(19) == 0);
            r_snap = bus.req;
            e_snap = bus.err_clr;
            #1;
            if (m_busy) begin
                check("rnd_mux_addr", bus.mem_addr, bus.req_addr[m_last*AW +: AW]);
                check("rnd_mux_rw", bus.mem_rw, bus.req_rw[m_last]);
                check("rnd_mux_wdata", bus.mem_wdata, bus.req_wdata[m_last*DW +: DW]);
            end else begin
                check("rnd_idle_addr", bus.mem_addr, 0);
                check("rnd_idle_rw", bus.mem_rw, 1);
                check("rnd_idle_wdata", bus.mem_wdata, 0);
            end
            step();
            model_edge(r_snap, e_snap);
            check("rnd_grant", bus.grant, m_busy ? (N'(1) << m_last) : N'(0));
            check("rnd_busy", bus.busy, m_busy);
            check("rnd_owner", bus.owner_id, m_last);
            check("rnd_terr", bus.timeout_err, m_err);
            check("rnd_tid", bus.timeout_id, m_tid);
        end
        bus.req = '0;
        bus.err_clr = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
